pfm_channel_scheduler: RTL and testbench

//  Sequences one ProducePartialFM engine over multiple input channels. For each channel it fetches
//  the input tile and kernel triple, restarts the engine, waits for completion and accumulates the

---
 rtl/pfm_pkg.sv | 27 ++
 rtl/pfm_sat_acc.sv | 38 +++
 rtl/pfm_channel_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_pfm_channel_scheduler.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfm_pkg.sv
// Shared definitions for the partial-FM channel scheduler: Q1.15 helpers and FSM state encoding.
package pfm_pkg;

  localparam int unsigned Q_W = 16;
  localparam logic [Q_W-1:0] Q15_MAX = 16'h7fff;
  localparam logic [Q_W-1:0] Q15_MIN = 16'h8000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLaunch,
    StWait,
    StAccum,
    StOutput
  } state_e;

  // Overflow shows up as disagreement between the two top bits of the sign-extended sum.
  function automatic logic [Q_W-1:0] sat_add16(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
    logic [Q_W:0] sum;
    sum = {a[Q_W-1], a} + {b[Q_W-1], b};
    if (sum[Q_W] != sum[Q_W-1]) begin
      return sum[Q_W] ? Q15_MIN : Q15_MAX;
    end
    return sum[Q_W-1:0];
  endfunction

endpackage

// File: rtl/pfm_sat_acc.sv
// N-lane parallel Q1.15 saturating accumulator with synchronous clear and add-enable.
module pfm_sat_acc
  import pfm_pkg::*;
#(
  parameter int unsigned LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [Q_W*LANES-1:0] add,
  output logic [Q_W*LANES-1:0] acc
);

  logic [Q_W*LANES-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_d[i*Q_W +: Q_W] = sat_add16(acc_q[i*Q_W +: Q_W], add[i*Q_W +: Q_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pfm_channel_scheduler.sv
// Runs one ProducePartialFM engine across the channels of a job and sums its three partial FMs
// into saturating accumulators presented through a valid/ready handshake.
module pfm_channel_scheduler
  import pfm_pkg::*;
#(
  parameter int unsigned IP_SIZE     = 6,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned MAX_CH      = 4,
  parameter int unsigned PFM_RST_CYC = 2,
  parameter int unsigned TIMEOUT     = 4096,
  localparam int unsigned OP_SIZE    = IP_SIZE - KERNEL_SIZE + 1,
  localparam int unsigned CW         = $clog2(MAX_CH + 1),
  localparam int unsigned IPW        = Q_W * IP_SIZE * IP_SIZE,
  localparam int unsigned KW         = Q_W * KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned LANES      = OP_SIZE * OP_SIZE,
  localparam int unsigned FW         = Q_W * LANES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_num_ch,
  output logic          busy,
  output logic          ch_req,
  output logic [CW-1:0] ch_idx,
  input  logic          ch_valid,
  input  logic [IPW-1:0] ch_ipf,
  input  logic [KW-1:0] ch_k1f,
  input  logic [KW-1:0] ch_k2f,
  input  logic [KW-1:0] ch_k3f,
  output logic          pfm_rst,
  output logic [IPW-1:0] pfm_ipf,
  output logic [KW-1:0] pfm_k1f,
  output logic [KW-1:0] pfm_k2f,
  output logic [KW-1:0] pfm_k3f,
  input  logic [FW-1:0] pfm_ik1,
  input  logic [FW-1:0] pfm_ik2,
  input  logic [FW-1:0] pfm_ik3,
  input  logic          pfm_resting,
  output logic [FW-1:0] acc_ik1,
  output logic [FW-1:0] acc_ik2,
  output logic [FW-1:0] acc_ik3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);

  localparam int unsigned RW = $clog2(PFM_RST_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e        state_d, state_q;
  logic [CW-1:0] num_ch_d, num_ch_q;
  logic [CW-1:0] ch_idx_d, ch_idx_q;
  logic [RW-1:0] rst_cnt_d, rst_cnt_q;
  logic [TW-1:0] wait_cnt_d, wait_cnt_q;
  logic          armed_d, armed_q;
  logic          err_d, err_q;
  logic          op_load, acc_clr, acc_en;

  logic [IPW-1:0] ipf_q;
  logic [KW-1:0]  k1f_q, k2f_q, k3f_q;

  always_comb begin
    state_d    = state_q;
    num_ch_d   = num_ch_q;
    ch_idx_d   = ch_idx_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    armed_d    = armed_q;
    err_d      = err_q;
    op_load    = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_num_ch == '0) begin
            num_ch_d = CW'(1);
          end else if (cfg_num_ch > CW'(MAX_CH)) begin
            num_ch_d = CW'(MAX_CH);
          end else begin
            num_ch_d = cfg_num_ch;
          end
          err_d    = 1'b0;
          acc_clr  = 1'b1;
          ch_idx_d = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (ch_valid) begin
          op_load   = 1'b1;
          rst_cnt_d = '0;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        if (rst_cnt_q == RW'(PFM_RST_CYC - 1)) begin
          wait_cnt_d = '0;
          armed_d    = 1'b0;
          state_d    = StWait;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        // A resting flag left high from the previous run only counts once it has dropped.
        if (!pfm_resting) begin
          armed_d = 1'b1;
        end
        if (armed_q && pfm_resting) begin
          state_d = StAccum;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          acc_clr = 1'b1;
          state_d = StOutput;
        end
      end
      StAccum: begin
        acc_en = 1'b1;
        if (ch_idx_q == num_ch_q - CW'(1)) begin
          state_d = StOutput;
        end else begin
          ch_idx_d = ch_idx_q + CW'(1);
          state_d  = StFetch;
        end
      end
      StOutput: begin
        if (out_ready) begin
          ch_idx_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      num_ch_q   <= CW'(1);
      ch_idx_q   <= '0;
      rst_cnt_q  <= '0;
      wait_cnt_q <= '0;
      armed_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_ch_q   <= num_ch_d;
      ch_idx_q   <= ch_idx_d;
      rst_cnt_q  <= rst_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      armed_q    <= armed_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ipf_q <= '0;
      k1f_q <= '0;
      k2f_q <= '0;
      k3f_q <= '0;
    end else if (op_load) begin
      ipf_q <= ch_ipf;
      k1f_q <= ch_k1f;
      k2f_q <= ch_k2f;
      k3f_q <= ch_k3f;
    end
  end

  pfm_sat_acc #(.LANES(LANES)) u_acc1 (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .add (pfm_ik1),
    .acc (acc_ik1)
  );

  pfm_sat_acc #(.LANES(LANES)) u_acc2 (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .add (pfm_ik2),
    .acc (acc_ik2)
  );

  pfm_sat_acc #(.LANES(LANES)) u_acc3 (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .add (pfm_ik3),
    .acc (acc_ik3)
  );

  assign busy      = (state_q != StIdle);
  assign ch_req    = (state_q == StFetch);
  assign ch_idx    = ch_idx_q;
  assign pfm_rst   = (state_q == StIdle) || (state_q == StLaunch);
  assign out_valid = (state_q == StOutput);
  assign err       = err_q;
  assign pfm_ipf   = ipf_q;
  assign pfm_k1f   = k1f_q;
  assign pfm_k2f   = k2f_q;
  assign pfm_k3f   = k3f_q;

endmodule

// File: tb/tb_pfm_channel_scheduler.sv
// Bench for pfm_channel_scheduler: behavioural engine stub and channel buffer, per-scenario tasks.
module tb_pfm_channel_scheduler;

  localparam int IP   = 6;
  localparam int KS   = 3;
  localparam int OP   = IP - KS + 1;
  localparam int L    = OP * OP;
  localparam int MAXC = 4;
  localparam int CW   = 3;
  localparam int TO   = 64;
  localparam int IPW  = 16 * IP * IP;
  localparam int KW   = 16 * KS * KS;
  localparam int FW   = 16 * L;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [CW-1:0]  cfg_num_ch = '0;
  logic           busy, ch_req;
  logic [CW-1:0]  ch_idx;
  logic           ch_valid = 1'b0;
  logic [IPW-1:0] ch_ipf = '0;
  logic [KW-1:0]  ch_k1f = '0, ch_k2f = '0, ch_k3f = '0;
  logic           pfm_rst;
  logic [IPW-1:0] pfm_ipf;
  logic [KW-1:0]  pfm_k1f, pfm_k2f, pfm_k3f;
  logic [FW-1:0]  pfm_ik1 = '0, pfm_ik2 = '0, pfm_ik3 = '0;
  logic           pfm_resting = 1'b0;
  logic [FW-1:0]  acc_ik1, acc_ik2, acc_ik3;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           err;

  int n_cmp = 0;
  int n_fail = 0;
  int tbl [MAXC][3][L];
  int stub_mode = 0;  // 0: rests 20 cycles after restart, 1: stale-high then low 3 then high
  int never_ch = -1;  // channel whose engine run never finishes
  int log_q[$];
  logic [KW-1:0] last_k1, last_k2, last_k3;

  pfm_channel_scheduler #(
    .IP_SIZE     (IP),
    .KERNEL_SIZE (KS),
    .MAX_CH      (MAXC),
    .PFM_RST_CYC (2),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_num_ch  (cfg_num_ch),
    .busy        (busy),
    .ch_req      (ch_req),
    .ch_idx      (ch_idx),
    .ch_valid    (ch_valid),
    .ch_ipf      (ch_ipf),
    .ch_k1f      (ch_k1f),
    .ch_k2f      (ch_k2f),
    .ch_k3f      (ch_k3f),
    .pfm_rst     (pfm_rst),
    .pfm_ipf     (pfm_ipf),
    .pfm_k1f     (pfm_k1f),
    .pfm_k2f     (pfm_k2f),
    .pfm_k3f     (pfm_k3f),
    .pfm_ik1     (pfm_ik1),
    .pfm_ik2     (pfm_ik2),
    .pfm_ik3     (pfm_ik3),
    .pfm_resting (pfm_resting),
    .acc_ik1     (acc_ik1),
    .acc_ik2     (acc_ik2),
    .acc_ik3     (acc_ik3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Engine stub: outputs the table row selected by lane 0 of the registered input tile.
  initial begin : stub
    int cnt;
    int row;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (pfm_rst) cnt = 0;
      else cnt++;
      row = int'(pfm_ipf[2:0]);
      if (row >= MAXC) row = 0;
      if (pfm_rst) pfm_resting = (stub_mode == 1);
      else if (row == never_ch) pfm_resting = 1'b0;
      else if (stub_mode == 1) pfm_resting = (cnt <= 1) || (cnt >= 5);
      else pfm_resting = (cnt >= 20);
      for (int l = 0; l < L; l++) begin
        pfm_ik1[l*16 +: 16] = 16'(tbl[row][0][l]);
        pfm_ik2[l*16 +: 16] = 16'(tbl[row][1][l]);
        pfm_ik3[l*16 +: 16] = 16'(tbl[row][2][l]);
      end
    end
  end

  // Channel buffer: answers each request after 0..3 cycles, tags the tile with the channel index.
  initial begin : chbuf
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (ch_valid) begin
        ch_valid = 1'b0;
        dly = $urandom_range(0, 3);
      end else if (ch_req) begin
        if (dly == 0) begin
          for (int i = 0; i < IP * IP; i++) ch_ipf[i*16 +: 16] = 16'($urandom);
          for (int i = 0; i < KS * KS; i++) begin
            ch_k1f[i*16 +: 16] = 16'($urandom);
            ch_k2f[i*16 +: 16] = 16'($urandom);
            ch_k3f[i*16 +: 16] = 16'($urandom);
          end
          ch_ipf[15:0] = 16'(ch_idx);
          last_k1 = ch_k1f;
          last_k2 = ch_k2f;
          last_k3 = ch_k3f;
          log_q.push_back(int'(ch_idx));
          ch_valid = 1'b1;
        end else begin
          dly--;
        end
      end
    end
  end

  function automatic int clampn(input int n);
    return (n == 0) ? 1 : (n > MAXC) ? MAXC : n;
  endfunction

  // Reference: running Q1.15 sum clamped after every channel.
  function automatic logic [FW-1:0] model(input int n, input int b);
    logic [FW-1:0] v;
    int a;
    for (int l = 0; l < L; l++) begin
      a = 0;
      for (int c = 0; c < n; c++) begin
        a = a + tbl[c][b][l];
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
      end
      v[l*16 +: 16] = 16'(a);
    end
    return v;
  endfunction

  task automatic fill_const(input int v1, input int v2, input int v3);
    for (int c = 0; c < MAXC; c++)
      for (int l = 0; l < L; l++) begin
        tbl[c][0][l] = v1;
        tbl[c][1][l] = v2;
        tbl[c][2][l] = v3;
      end
  endtask

  task automatic fill_rand();
    for (int c = 0; c < MAXC; c++)
      for (int b = 0; b < 3; b++)
        for (int l = 0; l < L; l++)
          if ($urandom_range(0, 1) == 0) tbl[c][b][l] = int'($urandom_range(0, 6000)) - 3000;
          else tbl[c][b][l] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    log_q.delete();
    start = 1'b1;
    cfg_num_ch = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, ch_req, out_valid, err, pfm_rst} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00001", {busy, ch_req, out_valid, err, pfm_rst});
    end
    n_cmp++;
    if (ch_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_ch_idx got %0d want 0", ch_idx);
    end
    n_cmp++;
    if ({acc_ik1, acc_ik2, acc_ik3} !== '0) begin
      n_fail++;
      $display("FAIL reset_acc got %h want 0", {acc_ik1, acc_ik2, acc_ik3});
    end
    n_cmp++;
    if ({pfm_ipf, pfm_k1f, pfm_k2f, pfm_k3f} !== '0) begin
      n_fail++;
      $display("FAIL reset_operands got nonzero %h want 0", pfm_ipf[63:0]);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    bit good;
    int pulses;
    fill_const(4096, -2048, 0);
    do_start(4);
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done got out_valid=0 want 1 within budget");
    end
    n_cmp++;
    if (acc_ik1 !== model(4, 0)) begin
      n_fail++;
      $display("FAIL basic_acc1 got %h want %h", acc_ik1, model(4, 0));
    end
    n_cmp++;
    if (acc_ik2 !== model(4, 1)) begin
      n_fail++;
      $display("FAIL basic_acc2 got %h want %h", acc_ik2, model(4, 1));
    end
    n_cmp++;
    if (acc_ik3 !== model(4, 2)) begin
      n_fail++;
      $display("FAIL basic_acc3 got %h want %h", acc_ik3, model(4, 2));
    end
    n_cmp++;
    if ({pfm_k1f, pfm_k2f, pfm_k3f} !== {last_k1, last_k2, last_k3}) begin
      n_fail++;
      $display("FAIL basic_kernels got %h want %h", pfm_k1f, last_k1);
    end
    good = (log_q.size() == 4);
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] != i) good = 1'b0;
    n_cmp++;
    if (!good) begin
      n_fail++;
      $display("FAIL basic_ch_seq got %0d fetches (first %0d) want 0,1,2,3", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : -1);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse got %0d valid cycles busy=%b want 1 and busy=0", pulses, busy);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    fill_const(12000, -10000, 7);
    do_start(4);
    wait_valid(ok);
    n_cmp++;
    if (!ok || acc_ik1 !== model(4, 0) || acc_ik2 !== model(4, 1)) begin
      n_fail++;
      $display("FAIL sat_acc got %h / %h want %h / %h", acc_ik1[15:0], acc_ik2[15:0],
               model(4, 0) & 16'hffff, model(4, 1) & 16'hffff);
    end
    finish_job();
    fill_rand();
    do_start(0);
    wait_valid(ok);
    n_cmp++;
    if (!ok || log_q.size() != 1 || acc_ik1 !== model(1, 0) || acc_ik3 !== model(1, 2)) begin
      n_fail++;
      $display("FAIL zero_ch got %0d fetches acc %h want 1 fetch acc %h", log_q.size(),
               acc_ik1, model(1, 0));
    end
    finish_job();
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    fill_const(100, 200, 300);
    never_ch = 1;
    do_start(2);
    for (int i = 0; i < 500 && !(busy && pfm_rst && ch_idx == 1); i++) @(negedge clk);
    for (int i = 0; i < 10 && pfm_rst; i++) @(negedge clk);
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != TO + 1) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d want %0d", k, TO + 1);
    end
    n_cmp++;
    if (err !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err got err=%b valid=%b want 1 1", err, out_valid);
    end
    n_cmp++;
    if ({acc_ik1, acc_ik2, acc_ik3} !== '0) begin
      n_fail++;
      $display("FAIL timeout_acc got %h want 0", acc_ik1);
    end
    finish_job();
    never_ch = -1;
    do_start(1);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b want 0", err);
    end
    wait_valid(ok);
    n_cmp++;
    if (!ok || err !== 1'b0 || acc_ik3 !== model(1, 2)) begin
      n_fail++;
      $display("FAIL after_timeout got err=%b acc %h want 0 %h", err, acc_ik3, model(1, 2));
    end
    finish_job();
  endtask

  task automatic test_stale();
    int k;
    fill_rand();
    stub_mode = 1;
    do_start(1);
    for (int i = 0; i < 100 && !(busy && pfm_rst); i++) @(negedge clk);
    for (int i = 0; i < 10 && pfm_rst; i++) @(negedge clk);
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != 7) begin
      n_fail++;
      $display("FAIL stale_latency got %0d want 7", k);
    end
    n_cmp++;
    if (acc_ik1 !== model(1, 0)) begin
      n_fail++;
      $display("FAIL stale_acc got %h want %h", acc_ik1, model(1, 0));
    end
    finish_job();
    stub_mode = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3*FW-1:0] snap;
    fill_rand();
    out_ready = 1'b0;
    do_start(3);
    for (int i = 0; i < 3000 && !out_valid; i++) begin
      start = (i % 7 == 3);
      cfg_num_ch = CW'(1);
      @(negedge clk);
    end
    start = 1'b0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || acc_ik2 !== model(3, 1) || log_q.size() != 3) begin
      n_fail++;
      $display("FAIL bp_acc got %0d fetches acc %h want 3 fetches %h", log_q.size(), acc_ik2,
               model(3, 1));
    end
    snap = {acc_ik1, acc_ik2, acc_ik3};
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 1);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || {acc_ik1, acc_ik2, acc_ik3} !== snap) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got valid=%b acc %h want 1 %h", i, out_valid,
                 acc_ik1, snap[3*FW-1 -: FW]);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || {acc_ik1, acc_ik2, acc_ik3} !== snap) begin
      n_fail++;
      $display("FAIL bp_release got busy=%b valid=%b want 0 0 with acc held", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_rand();
    do_start(4);
    for (int i = 0; i < 1000 && !(busy && ch_idx == 2 && !ch_req && !pfm_rst); i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ch_req, out_valid, err, pfm_rst} !== 5'b00001 || ch_idx !== '0) begin
      n_fail++;
      $display("FAIL midreset_ctrl got %b idx %0d want 00001 idx 0",
               {busy, ch_req, out_valid, err, pfm_rst}, ch_idx);
    end
    n_cmp++;
    if ({acc_ik1, acc_ik2, acc_ik3} !== '0 || {pfm_ipf, pfm_k1f} !== '0) begin
      n_fail++;
      $display("FAIL midreset_data got acc %h want 0", acc_ik1);
    end
    @(negedge clk);
    rst = 1'b1;
    fill_rand();
    do_start(2);
    wait_valid(ok);
    n_cmp++;
    if (!ok || acc_ik1 !== model(2, 0) || acc_ik2 !== model(2, 1)) begin
      n_fail++;
      $display("FAIL midreset_rerun got %h want %h", acc_ik1, model(2, 0));
    end
    finish_job();
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int j = 0; j < 6; j++) begin
      fill_rand();
      n = $urandom_range(0, 7);
      out_ready = 1'b0;
      do_start(n);
      wait_valid(ok);
      n_cmp++;
      if (!ok || log_q.size() != clampn(n) || acc_ik1 !== model(clampn(n), 0) ||
          acc_ik2 !== model(clampn(n), 1) || acc_ik3 !== model(clampn(n), 2)) begin
        n_fail++;
        $display("FAIL random job %0d n=%0d got %0d fetches acc1 %h want %0d fetches %h", j, n,
                 log_q.size(), acc_ik1, clampn(n), model(clampn(n), 0));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_job();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_rand();
    do_start(1);
    wait_valid(ok);
    start = 1'b1;
    cfg_num_ch = CW'(2);
    log_q.delete();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got busy=%b want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept got busy=%b ch_req=%b want 1 1", busy, ch_req);
    end
    wait_valid(ok);
    n_cmp++;
    if (!ok || log_q.size() != 2 || acc_ik3 !== model(2, 2)) begin
      n_fail++;
      $display("FAIL b2b_acc got %0d fetches %h want 2 fetches %h", log_q.size(), acc_ik3,
               model(2, 2));
    end
    finish_job();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_timeout();
    test_stale();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
